// File: rtl/clock_pkg.sv
// Shared constants for the clock field counters: per-field modulo, value
// widths and the direction encoding used by the run-mode dir input.
package clock_pkg;

  localparam int SEC_MODULO     = 60;
  localparam int MIN_MODULO     = 60;
  localparam int HOUR24_MODULO  = 24;
  localparam int HOUR12_MODULO  = 12;

  localparam int SEC_BIT        = 6;
  localparam int MIN_BIT        = 6;
  localparam int HOUR_BIT       = 5;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

endpackage

// File: rtl/mod_tick_counter.sv
// Modulo-P_MODULO field counter with run (up/down with carry), setting
// (adjust without carry) and parallel-load modes; one instance per clock field.
module mod_tick_counter
  import clock_pkg::*;
#(
  parameter int P_MODULO = 60,
  parameter int P_BIT    = 6,
  parameter int P_INIT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             tick_in,
  input  logic             dir,
  input  logic             set_mode,
  input  logic             inc_req,
  input  logic             dec_req,
  input  logic             load,
  input  logic [P_BIT-1:0] load_val,
  output logic [P_BIT-1:0] value,
  output logic             carry_tick,
  output logic             at_term,
  output logic             load_err
);

  localparam logic [P_BIT-1:0] VAL_MAX  = P_BIT'(P_MODULO - 1);
  localparam logic [P_BIT-1:0] VAL_INIT = P_BIT'(P_INIT);
  localparam logic [P_BIT-1:0] VAL_ZERO = '0;
  localparam logic [P_BIT-1:0] VAL_ONE  = P_BIT'(1);

  logic [P_BIT-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             load_err_q, load_err_d;
  logic             at_max, at_zero, load_ok;
  logic [P_BIT-1:0] value_inc, value_dec;

  assign at_max    = (value_q == VAL_MAX);
  assign at_zero   = (value_q == VAL_ZERO);
  // Wrap on P_MODULO-1, never on the natural 2**P_BIT rollover.
  assign value_inc = at_max  ? VAL_ZERO : value_q + VAL_ONE;
  assign value_dec = at_zero ? VAL_MAX  : value_q - VAL_ONE;
  assign load_ok   = (32'(load_val) < P_MODULO);

  always_comb begin
    value_d    = value_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) value_d    = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (set_mode) begin
        // Adjusting a field never carries into the next field.
        if (inc_req && !dec_req)      value_d = value_inc;
        else if (dec_req && !inc_req) value_d = value_dec;
      end else if (tick_in) begin
        if (dir == DIR_UP) begin
          value_d = value_inc;
          carry_d = at_max;
        end else begin
          value_d = value_dec;
          carry_d = at_zero;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q    <= VAL_INIT;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign value      = value_q;
  assign carry_tick = carry_q;
  assign load_err   = load_err_q;
  assign at_term    = (dir == DIR_DOWN) ? at_zero : at_max;

endmodule

// File: tb/tb_mod_tick_counter.sv
// Self-checking bench: a behavioural model of a modulo-60 field checked every
// cycle under directed and random stimulus, plus a sec/min/hour cascade.
module tb_mod_tick_counter;
  import clock_pkg::*;

  localparam int M = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, tick_in = 1'b0, dir = 1'b0;
  logic       set_mode = 1'b0, inc_req = 1'b0, dec_req = 1'b0, load = 1'b0;
  logic [5:0] load_val = '0;
  logic [5:0] value;
  logic       carry_tick, at_term, load_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  int mval = 0;
  bit mcarry = 1'b0, merr = 1'b0;

  always #5 clk = ~clk;

  mod_tick_counter #(.P_MODULO(M), .P_BIT(6), .P_INIT(0)) dut (
    .clk(clk), .reset(reset), .en(en), .tick_in(tick_in), .dir(dir),
    .set_mode(set_mode), .inc_req(inc_req), .dec_req(dec_req), .load(load),
    .load_val(load_val), .value(value), .carry_tick(carry_tick),
    .at_term(at_term), .load_err(load_err)
  );

  // Cascade: seconds -> minutes -> 24h hours.
  logic       c_en = 1'b0, c_tick = 1'b0, c_load = 1'b0;
  logic [5:0] c_sec_lv = '0, c_min_lv = '0;
  logic [4:0] c_hour_lv = '0;
  logic [5:0] sec_v, min_v;
  logic [4:0] hour_v;
  logic       sec_c, min_c, hour_c;
  logic       sec_t, min_t, hour_t, sec_e, min_e, hour_e;

  mod_tick_counter #(.P_MODULO(SEC_MODULO), .P_BIT(SEC_BIT), .P_INIT(0)) u_sec (
    .clk(clk), .reset(reset), .en(c_en), .tick_in(c_tick), .dir(DIR_UP),
    .set_mode(1'b0), .inc_req(1'b0), .dec_req(1'b0), .load(c_load),
    .load_val(c_sec_lv), .value(sec_v), .carry_tick(sec_c),
    .at_term(sec_t), .load_err(sec_e)
  );
  mod_tick_counter #(.P_MODULO(MIN_MODULO), .P_BIT(MIN_BIT), .P_INIT(0)) u_min (
    .clk(clk), .reset(reset), .en(c_en), .tick_in(sec_c), .dir(DIR_UP),
    .set_mode(1'b0), .inc_req(1'b0), .dec_req(1'b0), .load(c_load),
    .load_val(c_min_lv), .value(min_v), .carry_tick(min_c),
    .at_term(min_t), .load_err(min_e)
  );
  mod_tick_counter #(.P_MODULO(HOUR24_MODULO), .P_BIT(HOUR_BIT), .P_INIT(0)) u_hour (
    .clk(clk), .reset(reset), .en(c_en), .tick_in(min_c), .dir(DIR_UP),
    .set_mode(1'b0), .inc_req(1'b0), .dec_req(1'b0), .load(c_load),
    .load_val(c_hour_lv), .value(hour_v), .carry_tick(hour_c),
    .at_term(hour_t), .load_err(hour_e)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the field's rules written as plain modular arithmetic.
  always @(posedge clk) begin
    if (reset) begin
      mval = 0; mcarry = 1'b0; merr = 1'b0;
    end else begin
      mcarry = 1'b0; merr = 1'b0;
      if (load) begin
        if (int'(load_val) < M) mval = int'(load_val);
        else                    merr = 1'b1;
      end else if (en) begin
        if (set_mode) begin
          if (inc_req && !dec_req)      mval = (mval + 1) % M;
          else if (dec_req && !inc_req) mval = (mval + M - 1) % M;
        end else if (tick_in) begin
          if (!dir) begin
            mcarry = (mval == M - 1);
            mval   = (mval + 1) % M;
          end else begin
            mcarry = (mval == 0);
            mval   = (mval + M - 1) % M;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_value", int'(value), mval);
      check("model_carry", int'(carry_tick), int'(mcarry));
      check("model_load_err", int'(load_err), int'(merr));
      check("model_at_term", int'(at_term), dir ? int'(mval == 0) : int'(mval == M - 1));
    end
  end

  // Inputs change just after the negative edge, away from both sampling points.
  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_idle();
    tick_in = 1'b0; inc_req = 1'b0; dec_req = 1'b0; load = 1'b0;
  endtask

  initial begin
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    chk_on = 1'b1;
    check("reset_value", int'(value), 0);
    check("reset_carry", int'(carry_tick), 0);
    check("reset_load_err", int'(load_err), 0);
    reset = 1'b0; en = 1'b1;

    // Reset wins over a concurrent tick.
    tick_in = 1'b1; cycle();
    check("tick_once", int'(value), 1);
    reset = 1'b1; cycle();
    check("reset_over_tick", int'(value), 0);
    reset = 1'b0; pulse_idle();

    // Run up across the wrap.
    load = 1'b1; load_val = 6'd58; cycle(); load = 1'b0;
    check("load58", int'(value), 58);
    tick_in = 1'b1; cycle();
    check("up_59", int'(value), 59);
    check("up_at_term59", int'(at_term), 1);
    check("up_no_carry", int'(carry_tick), 0);
    cycle();
    check("up_wrap0", int'(value), 0);
    check("up_carry", int'(carry_tick), 1);
    tick_in = 1'b0; cycle();
    check("up_carry_once", int'(carry_tick), 0);

    // Run down across the wrap.
    load = 1'b1; load_val = 6'd1; dir = 1'b1; cycle(); load = 1'b0;
    tick_in = 1'b1; cycle();
    check("dn_0", int'(value), 0);
    check("dn_at_term0", int'(at_term), 1);
    check("dn_no_carry", int'(carry_tick), 0);
    cycle();
    check("dn_wrap59", int'(value), 59);
    check("dn_carry", int'(carry_tick), 1);
    tick_in = 1'b0; cycle();
    check("dn_carry_once", int'(carry_tick), 0);
    dir = 1'b0;

    // Setting mode: wraps without carry, both requests cancel, ticks ignored.
    set_mode = 1'b1;
    inc_req = 1'b1; cycle(); inc_req = 1'b0;
    check("set_inc_wrap", int'(value), 0);
    check("set_no_carry", int'(carry_tick), 0);
    dec_req = 1'b1; cycle(); dec_req = 1'b0;
    check("set_dec_wrap", int'(value), 59);
    inc_req = 1'b1; dec_req = 1'b1; tick_in = 1'b1; cycle(); pulse_idle();
    check("set_both_hold", int'(value), 59);
    tick_in = 1'b1; cycle(); cycle(); tick_in = 1'b0;
    check("set_tick_ignored", int'(value), 59);
    set_mode = 1'b0;

    // Load rejection, then load beating a wrapping tick.
    load = 1'b1; load_val = 6'd60; cycle(); load = 1'b0;
    check("bad_load_hold", int'(value), 59);
    check("bad_load_err", int'(load_err), 1);
    cycle();
    check("bad_load_err_once", int'(load_err), 0);
    load = 1'b1; load_val = 6'd10; tick_in = 1'b1; cycle(); pulse_idle();
    check("load_over_tick", int'(value), 10);
    check("load_no_carry", int'(carry_tick), 0);

    // en=0 freezes counting but still honours load.
    en = 1'b0; tick_in = 1'b1; cycle(); cycle();
    check("en0_hold", int'(value), 10);
    load = 1'b1; load_val = 6'd33; cycle(); pulse_idle();
    check("en0_load", int'(value), 33);
    en = 1'b1;

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      en       = ($urandom_range(0, 7) != 0);
      set_mode = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      tick_in  = ($urandom_range(0, 1) == 1);
      inc_req  = ($urandom_range(0, 2) == 0);
      dec_req  = ($urandom_range(0, 2) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 6'($urandom_range(0, 63));
      cycle();
    end
    reset = 1'b0; en = 1'b1; set_mode = 1'b0; dir = 1'b0; pulse_idle();
    cycle();

    // Cascade from 23:59:59.
    c_en = 1'b1; c_load = 1'b1;
    c_sec_lv = 6'd59; c_min_lv = 6'd59; c_hour_lv = 5'd23;
    cycle(); c_load = 1'b0;
    check("cas_load", int'(hour_v) * 3600 + int'(min_v) * 60 + int'(sec_v), 86399);
    c_tick = 1'b1; cycle(); c_tick = 1'b0;
    check("cas_sec0", int'(sec_v), 0);
    check("cas_sec_carry", int'(sec_c), 1);
    check("cas_min_still59", int'(min_v), 59);
    cycle();
    check("cas_min0", int'(min_v), 0);
    check("cas_min_carry", int'(min_c), 1);
    check("cas_sec_carry_once", int'(sec_c), 0);
    cycle();
    check("cas_hour0", int'(hour_v), 0);
    check("cas_hour_carry", int'(hour_c), 1);
    check("cas_min_carry_once", int'(min_c), 0);
    cycle();
    check("cas_hour_carry_once", int'(hour_c), 0);
    check("cas_midnight", int'(hour_v) * 3600 + int'(min_v) * 60 + int'(sec_v), 0);

    // Frozen cascade.
    c_load = 1'b1; cycle(); c_load = 1'b0;
    c_en = 1'b0; c_tick = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    c_tick = 1'b0;
    check("cas_frozen", int'(hour_v) * 3600 + int'(min_v) * 60 + int'(sec_v), 86399);
    check("cas_frozen_carry", int'(sec_c) + int'(min_c) + int'(hour_c), 0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
